// File: rtl/step_dir_decoder.sv
// Step/dir receiver behind an APB3 slot: decodes step pulses into a signed position
// and a total-step count, with glitch detection and a position-limit interrupt.
module step_dir_decoder #(
  parameter int POS_W       = 32,
  parameter int MIN_PULSE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        step_in,
  input  logic        dir_in,
  output logic        irq
);

  localparam int HC_W = $clog2(MIN_PULSE + 1) + 1;

  typedef enum logic [1:0] {IDLE, HIGH, WAIT_LOW} state_t;

  state_t                   r_state;
  logic [HC_W-1:0]          r_hc;
  logic [SYNC_STAGES-1:0]   r_stepSync;
  logic [SYNC_STAGES-1:0]   r_dirSync;
  logic                     r_en;
  logic                     r_dirInv;
  logic                     r_irqEn;
  logic signed [POS_W-1:0]  r_pos;
  logic signed [POS_W-1:0]  r_limit;
  logic [POS_W-1:0]         r_stepCount;
  logic [15:0]              r_glitchCount;
  logic                     r_limitHit;
  logic                     r_glitch;
  logic                     r_irq;

  logic                     w_stepS;
  logic                     w_dirEff;
  logic [HC_W-1:0]          w_hcNext;
  logic                     w_commit;
  logic                     w_glitchEvt;
  logic                     w_wr;
  logic [2:0]               w_idx;
  logic                     w_wrCtrl;
  logic                     w_wrPos;
  logic                     w_wrStatus;
  logic                     w_wrLimit;
  logic                     w_wrSteps;
  logic                     w_wrGlitchCnt;
  logic                     w_clr;
  logic signed [POS_W-1:0]  w_posStep;
  logic                     w_hit;
  logic                     w_unused;

  assign w_stepS  = r_stepSync[SYNC_STAGES-1];
  assign w_dirEff = r_dirSync[SYNC_STAGES-1] ^ r_dirInv;

  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_idx         = PADDR[4:2];
  assign w_wrCtrl      = w_wr && (w_idx == 3'd0);
  assign w_wrPos       = w_wr && (w_idx == 3'd1);
  assign w_wrStatus    = w_wr && (w_idx == 3'd2);
  assign w_wrLimit     = w_wr && (w_idx == 3'd3);
  assign w_wrSteps     = w_wr && (w_idx == 3'd4);
  assign w_wrGlitchCnt = w_wr && (w_idx == 3'd5);
  assign w_clr         = w_wrCtrl && PWDATA[2];

  // A pulse commits on the edge where its MIN_PULSE-th high sample is seen.
  assign w_hcNext    = r_hc + HC_W'(1);
  assign w_commit    = r_en && w_stepS &&
                       (((r_state == IDLE) && (MIN_PULSE == 1)) ||
                        ((r_state == HIGH) && (w_hcNext == HC_W'(MIN_PULSE))));
  assign w_glitchEvt = r_en && !w_stepS && (r_state == HIGH);

  assign w_posStep = w_dirEff ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
  assign w_hit     = w_commit && !w_wrPos && !w_clr && (w_posStep == r_limit);

  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & w_idx[2] & w_idx[1];
  assign irq      = r_irq;
  assign w_unused = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_stepSync <= '0;
      r_dirSync  <= '0;
    end else begin
      r_stepSync <= {r_stepSync[SYNC_STAGES-2:0], step_in};
      r_dirSync  <= {r_dirSync[SYNC_STAGES-2:0], dir_in};
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state <= IDLE;
      r_hc    <= '0;
    end else if (!r_en) begin
      r_state <= IDLE;
      r_hc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stepS) begin
            r_hc    <= HC_W'(1);
            r_state <= (MIN_PULSE == 1) ? WAIT_LOW : HIGH;
          end
        end
        HIGH: begin
          if (!w_stepS) begin
            r_state <= IDLE;
          end else begin
            r_hc <= w_hcNext;
            if (w_commit) r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!w_stepS) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A firmware write (or CLR) beats a simultaneous commit for POS; STEP_COUNT still counts it.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_en          <= 1'b0;
      r_dirInv      <= 1'b0;
      r_irqEn       <= 1'b0;
      r_pos         <= '0;
      r_limit       <= '0;
      r_stepCount   <= '0;
      r_glitchCount <= '0;
      r_limitHit    <= 1'b0;
      r_glitch      <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (w_wrCtrl) begin
        r_en     <= PWDATA[0];
        r_dirInv <= PWDATA[1];
        r_irqEn  <= PWDATA[3];
      end

      if (w_wrPos)       r_pos <= PWDATA[POS_W-1:0];
      else if (w_clr)    r_pos <= '0;
      else if (w_commit) r_pos <= w_posStep;

      if (w_wrLimit) r_limit <= PWDATA[POS_W-1:0];

      if (w_wrSteps)     r_stepCount <= '0;
      else if (w_commit) r_stepCount <= r_stepCount + POS_W'(1);

      if (w_wrGlitchCnt) r_glitchCount <= '0;
      else if (w_glitchEvt && (r_glitchCount != 16'hFFFF))
        r_glitchCount <= r_glitchCount + 16'd1;

      if (w_hit)                         r_limitHit <= 1'b1;
      else if (w_wrStatus && PWDATA[0])  r_limitHit <= 1'b0;

      if (w_glitchEvt)                   r_glitch <= 1'b1;
      else if (w_wrStatus && PWDATA[1])  r_glitch <= 1'b0;

      r_irq <= r_limitHit & r_irqEn;
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (w_idx)
        3'd0:    PRDATA = {28'd0, r_irqEn, 1'b0, r_dirInv, r_en};
        3'd1:    PRDATA = 32'(r_pos);
        3'd2:    PRDATA = {29'd0, w_dirEff, r_glitch, r_limitHit};
        3'd3:    PRDATA = 32'(r_limit);
        3'd4:    PRDATA = 32'(r_stepCount);
        3'd5:    PRDATA = {16'd0, r_glitchCount};
        default: PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboarded bench for step_dir_decoder: a register-level model predicts every APB
// read, and a monitor compares PRDATA/PSLVERR/irq whenever a read access completes.
module tb_step_dir_decoder;

  localparam int MIN_PULSE   = 4;
  localparam int SYNC_STAGES = 2;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        step_in, dir_in, irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        irqExp;
  } exp_t;

  exp_t sbQ[$];
  exp_t monEntry;
  int   checkCount = 0;
  int   passCount  = 0;

  logic        mEn, mDirInv, mIrqEn, mGlitch, mLimitHit;
  logic [31:0] mPos, mLimit, mSteps;
  logic [15:0] mGlitchCnt;

  step_dir_decoder #(.POS_W(32), .MIN_PULSE(MIN_PULSE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .step_in(step_in), .dir_in(dir_in), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every completed read access is matched against the oldest prediction.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (sbQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_read: got addr %h, expected no access", PADDR);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput($sformatf("prdata@%02h", monEntry.addr[7:0]), PRDATA, monEntry.data);
        checkOutput($sformatf("pslverr@%02h", monEntry.addr[7:0]), {31'd0, PSLVERR}, {31'd0, monEntry.err});
        checkOutput($sformatf("irq@%02h", monEntry.addr[7:0]), {31'd0, irq}, {31'd0, monEntry.irqExp});
      end
    end
  end

  task automatic modelReset();
    mEn = 0; mDirInv = 0; mIrqEn = 0; mGlitch = 0; mLimitHit = 0;
    mPos = 0; mLimit = 0; mSteps = 0; mGlitchCnt = 0;
  endtask

  task automatic modelCommit(input logic dir);
    if (dir ^ mDirInv) mPos = mPos + 32'd1;
    else               mPos = mPos - 32'd1;
    mSteps = mSteps + 32'd1;
    if (mPos == mLimit) mLimitHit = 1'b1;
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] addr);
    case (addr[4:2])
      3'd0:    return {28'd0, mIrqEn, 1'b0, mDirInv, mEn};
      3'd1:    return mPos;
      3'd2:    return {29'd0, dir_in ^ mDirInv, mGlitch, mLimitHit};
      3'd3:    return mLimit;
      3'd4:    return mSteps;
      3'd5:    return {16'd0, mGlitchCnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    apbWrite(addr, data);
    case (addr[4:2])
      3'd0: begin
        mEn = data[0]; mDirInv = data[1]; mIrqEn = data[3];
        if (data[2]) mPos = 0;
      end
      3'd1: mPos = data;
      3'd2: begin
        if (data[0]) mLimitHit = 0;
        if (data[1]) mGlitch = 0;
      end
      3'd3: mLimit = data;
      3'd4: mSteps = 0;
      3'd5: mGlitchCnt = 0;
      default: ;
    endcase
  endtask

  task automatic readReg(input logic [31:0] addr);
    exp_t e;
    e.addr = addr; e.data = expRead(addr);
    e.err = addr[4] & addr[3]; e.irqExp = mLimitHit & mIrqEn;
    sbQ.push_back(e);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic applyStimulus(input int width, input int gap, input logic dir);
    dir_in = dir; step_in = 1;
    repeat (width) @(posedge PCLK);
    #1 step_in = 0;
    repeat (gap) @(posedge PCLK);
    #1;
    if (mEn) begin
      if (width >= MIN_PULSE) modelCommit(dir);
      else begin
        mGlitch = 1;
        if (mGlitchCnt != 16'hFFFF) mGlitchCnt = mGlitchCnt + 16'd1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int limR;
    PRESERN = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    step_in = 0; dir_in = 0;
    modelReset();
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1;
    checkOutput("irq_after_reset", {31'd0, irq}, 32'd0);
    checkOutput("pready", {31'd0, PREADY}, 32'd1);
    for (int a = 0; a < 6; a++) readReg(32'(a * 4));

    writeReg(32'h00, 32'h1);
    for (int i = 0; i < 10; i++) applyStimulus(6, 6, 1'b1);
    readReg(32'h04); readReg(32'h10); readReg(32'h08);

    for (int i = 0; i < 3; i++) applyStimulus(6, 6, 1'b0);
    readReg(32'h04);
    writeReg(32'h00, 32'h3);
    for (int i = 0; i < 2; i++) applyStimulus(6, 6, 1'b0);
    readReg(32'h04);

    applyStimulus(2, 6, 1'b0);
    readReg(32'h04); readReg(32'h08); readReg(32'h14);
    writeReg(32'h08, 32'h2);
    readReg(32'h08);

    writeReg(32'h04, 32'hFFFF_FFFE);
    writeReg(32'h0C, 32'h0);
    writeReg(32'h00, 32'h9);
    applyStimulus(6, 6, 1'b1);
    dir_in = 1; step_in = 1; n = 0;
    while (irq !== 1'b1 && n < 20) begin
      @(posedge PCLK); #1 n++;
    end
    checkOutput("irq_latency_edges", 32'(n), 32'(SYNC_STAGES + MIN_PULSE + 1));
    step_in = 0;
    repeat (6) @(posedge PCLK);
    #1 modelCommit(1'b1);
    readReg(32'h04); readReg(32'h08);
    writeReg(32'h08, 32'h1);
    readReg(32'h08);
    writeReg(32'h04, 32'h0);
    readReg(32'h08);

    // POS write lands on the exact commit edge of this pulse.
    dir_in = 1; step_in = 1;
    repeat (4) @(posedge PCLK);
    #1 apbWrite(32'h04, 32'd100);
    step_in = 0;
    repeat (6) @(posedge PCLK);
    #1 mPos = 32'd100; mSteps = mSteps + 32'd1;
    readReg(32'h04); readReg(32'h10);
    readReg(32'h18);

    writeReg(32'h0C, 32'd99);
    dir_in = 0; step_in = 1;
    repeat (50) @(posedge PCLK);
    #1 modelCommit(1'b0);
    readReg(32'h04); readReg(32'h10); readReg(32'h08);
    PRESERN = 0;
    #2 checkOutput("irq_in_reset", {31'd0, irq}, 32'd0);
    modelReset();
    readReg(32'h00); readReg(32'h04); readReg(32'h08); readReg(32'h0C); readReg(32'h10);
    @(posedge PCLK); #1 PRESERN = 1;
    readReg(32'h04);
    writeReg(32'h00, 32'h1);
    repeat (10) @(posedge PCLK);
    #1 modelCommit(1'b0);
    readReg(32'h04); readReg(32'h10);
    step_in = 0;
    repeat (6) @(posedge PCLK);
    #1;

    limR = int'($urandom_range(0, 8)) - 4;
    writeReg(32'h0C, 32'(limR));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: writeReg(32'h00, {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
        1: writeReg(32'h04, 32'(int'($urandom_range(0, 8)) - 4));
        2: writeReg(32'h08, 32'($urandom_range(0, 3)));
        default: ;
      endcase
      applyStimulus(int'($urandom_range(1, 8)), int'($urandom_range(4, 8)), 1'($urandom_range(0, 1)));
      readReg(32'h04);
      if (i % 4 == 0) begin
        readReg(32'h08); readReg(32'h10); readReg(32'h14); readReg(32'h00);
      end
    end

    repeat (3) @(posedge PCLK);
    #1;
    if (sbQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
